// File: rtl/ikbd_port_arbiter_if.sv
// Bundle of the mouse/joystick signals that enter the IKBD port arbiter and the
// selected port value, source index and debounced joystick vectors it returns.
interface ikbd_port_arbiter_if #(
    parameter int NUM_JOY = 2
);
    localparam int SRC_W = $clog2(NUM_JOY + 1);

    logic [5:0]           mouse_in;
    logic [5*NUM_JOY-1:0] joy_in;
    logic [1:0]           mode;
    logic [SRC_W-1:0]     force_sel;
    logic [5:0]           port_out;
    logic [SRC_W-1:0]     active_src;
    logic                 switch_pulse;
    logic [5*NUM_JOY-1:0] joy_clean;

    // Upstream side: ps2/joystick inputs plus mode control.
    modport master (
        output mouse_in, joy_in, mode, force_sel,
        input  port_out, active_src, switch_pulse, joy_clean
    );

    // Arbiter side.
    modport slave (
        input  mouse_in, joy_in, mode, force_sel,
        output port_out, active_src, switch_pulse, joy_clean
    );
endinterface

// File: rtl/ikbd_port_arbiter.sv
// IKBD port-0 source arbiter: synchronises and debounces NUM_JOY joystick
// channels, then picks the mouse or a joystick by activity with a minimum hold
// time, or a forced source. The chosen 6-bit value is registered on port_out.
module ikbd_port_arbiter #(
    parameter int NUM_JOY     = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 2000
) (
    input  logic                clk,
    input  logic                res,
    ikbd_port_arbiter_if.slave  bus
);
    localparam int SRC_W = $clog2(NUM_JOY + 1);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_MAX = TMR_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_AUTO        = 2'b00,
        MODE_FORCE_MOUSE = 2'b01,
        MODE_FORCE_SEL   = 2'b10,
        MODE_AUTO_ALT    = 2'b11
    } mode_e;

    logic [NUM_JOY-1:0][4:0]       r_sync1;
    logic [NUM_JOY-1:0][4:0]       r_sync2;
    logic [NUM_JOY-1:0][4:0]       r_cand;
    logic [NUM_JOY-1:0][CNT_W-1:0] r_cnt;
    logic [NUM_JOY-1:0][4:0]       r_clean;
    logic [NUM_JOY-1:0][4:0]       r_last_clean;
    logic [5:0]                    r_last_mouse;
    logic [SRC_W-1:0]              r_src;
    logic [TMR_W-1:0]              r_tmr;
    logic                          r_pulse;
    logic [5:0]                    r_port;

    logic                          w_mouse_act;
    logic [NUM_JOY-1:0]            w_joy_act;
    logic                          w_cur_act;
    logic                          w_other_act;
    logic [SRC_W-1:0]              w_other_src;
    logic [SRC_W-1:0]              w_src_nxt;
    logic [TMR_W-1:0]              w_tmr_nxt;
    logic [5:0]                    w_port_nxt;

    // Two-flop synchroniser and per-channel stability debounce of the joysticks.
    // NOTE: every register in this design, including the per-channel arrays, is
    // cleared by reset so a mid-debounce reset leaves no stale candidate behind.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_cand       <= '0;
            r_cnt        <= '0;
            r_clean      <= '0;
            r_last_clean <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            r_sync1      <= bus.joy_in;
            r_sync2      <= r_sync1;
            r_last_clean <= r_clean;
            for (int k = 0; k < NUM_JOY; k++) begin
                if (r_sync2[k] != r_cand[k]) begin
                    r_cand[k] <= r_sync2[k];
                    r_cnt[k]  <= '0;
                end else if (r_cnt[k] < CNT_MAX) begin
                    r_cnt[k] <= r_cnt[k] + 1'b1;
                end else if (r_cand[k] != r_clean[k]) begin
                    r_clean[k] <= r_cand[k];
                end
            end
        end
    end

    // Activity: mouse value differs from last cycle, or a clean joystick vector just changed.
    always_comb begin
        // NOTE: defaults first so no path through this block infers a latch.
        w_joy_act   = '0;
        w_mouse_act = (bus.mouse_in != r_last_mouse);
        for (int k = 0; k < NUM_JOY; k++) begin
            w_joy_act[k] = (r_clean[k] != r_last_clean[k]);
        end
    end

    // Source selection: forced modes override; auto mode honours the hold timer.
    always_comb begin
        w_src_nxt   = r_src;
        w_tmr_nxt   = r_tmr;
        w_cur_act   = w_mouse_act;
        w_other_act = 1'b0;
        w_other_src = '0;
        for (int k = 0; k < NUM_JOY; k++) begin
            if (r_src == SRC_W'(k + 1)) w_cur_act = w_joy_act[k];
        end
        // Scan downward so the lowest-index joystick wins, then let the mouse beat all.
        for (int k = NUM_JOY - 1; k >= 0; k--) begin
            if (w_joy_act[k]) begin
                w_other_act = 1'b1;
                w_other_src = SRC_W'(k + 1);
            end
        end
        if (w_mouse_act) begin
            w_other_act = 1'b1;
            w_other_src = '0;
        end
        case (mode_e'(bus.mode))
            MODE_FORCE_MOUSE: begin
                w_src_nxt = '0;
                w_tmr_nxt = '0;
            end
            MODE_FORCE_SEL: begin
                w_src_nxt = (bus.force_sel > SRC_W'(NUM_JOY)) ? '0 : bus.force_sel;
                w_tmr_nxt = '0;
            end
            default: begin
                if (w_cur_act) begin
                    w_tmr_nxt = HOLD_MAX;
                end else if ((r_tmr == '0) && w_other_act) begin
                    w_src_nxt = w_other_src;
                    w_tmr_nxt = HOLD_MAX;
                end else if (r_tmr != '0) begin
                    w_tmr_nxt = r_tmr - 1'b1;
                end
            end
        endcase
    end

    // Port value from the source in effect at this edge (new source shows one cycle later).
    always_comb begin
        w_port_nxt = bus.mouse_in;
        for (int k = 0; k < NUM_JOY; k++) begin
            if (r_src == SRC_W'(k + 1)) w_port_nxt = {1'b0, r_clean[k]};
        end
    end

    // Selection state, switch pulse, mouse history and registered port output.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_src        <= '0;
            r_tmr        <= '0;
            r_pulse      <= 1'b0;
            r_port       <= '0;
            r_last_mouse <= '0;
        end else begin
            r_src        <= w_src_nxt;
            r_tmr        <= w_tmr_nxt;
            r_pulse      <= (w_src_nxt != r_src);
            r_port       <= w_port_nxt;
            r_last_mouse <= bus.mouse_in;
        end
    end

    assign bus.port_out     = r_port;
    assign bus.active_src   = r_src;
    assign bus.switch_pulse = r_pulse;
    assign bus.joy_clean    = r_clean;
endmodule
